// File: rtl/decode_ctrl_stage.sv
// ID-stage decoder feeding the ID/EX pipeline register.
// Handles load-use bubbles, branch flushes and a saturating bubble counter.
module decode_ctrl_stage #(
    parameter int INSTR_W = 9,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               flush,
    output logic [11:0]        ctrl_out,
    output logic               out_valid,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_ra,
    output logic [REG_AW-1:0]  out_rb,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam logic [2:0] OP_SUB = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    localparam logic [REG_AW-1:0] BR_JMP  = REG_AW'(3'b000);
    localparam logic [REG_AW-1:0] BR_INCP = REG_AW'(3'b100);
    localparam logic [REG_AW-1:0] BR_DECP = REG_AW'(3'b101);
    localparam logic [REG_AW-1:0] BR_INCB = REG_AW'(3'b110);
    localparam logic [REG_AW-1:0] BR_DECB = REG_AW'(3'b111);

    // ctrl_out bit positions
    localparam int B_REGW = 11;
    localparam int B_MEMR = 10;
    localparam int B_MEMW = 9;
    localparam int B_BRN  = 8;
    localparam int B_M2R  = 7;
    localparam int B_OPLO = 4;
    localparam int B_INCP = 3;
    localparam int B_DECP = 2;
    localparam int B_INCB = 1;
    localparam int B_DECB = 0;

    logic [2:0]        w_op;
    logic [REG_AW-1:0] w_ra;
    logic [REG_AW-1:0] w_rb;
    logic [11:0]       w_dec;
    logic              w_reads_ra;
    logic              w_reads_rb;
    logic              w_match;
    logic              w_bubble_inc;

    logic [11:0]       r_ctrl;
    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_ra;
    logic [REG_AW-1:0] r_rb;
    logic [CNT_W-1:0]  r_cnt;

    assign w_op = instr[INSTR_W-1 -: 3];
    assign w_ra = instr[2*REG_AW-1 -: REG_AW];
    assign w_rb = instr[REG_AW-1:0];

    always_comb begin
        w_dec      = '0;
        w_reads_ra = 1'b0;
        w_reads_rb = 1'b0;
        case (w_op)
            OP_SUB, OP_XOR, OP_SHL, OP_SHR, OP_ADD: begin
                w_dec[B_REGW]          = 1'b1;
                w_dec[B_OPLO +: 3]     = w_op;
                w_reads_ra             = 1'b1;
                w_reads_rb             = 1'b1;
            end
            OP_LW: begin
                w_dec[B_REGW]          = 1'b1;
                w_dec[B_MEMR]          = 1'b1;
                w_dec[B_M2R]           = 1'b1;
                w_dec[B_OPLO +: 3]     = OP_LW;
                w_reads_rb             = 1'b1;
            end
            OP_SW: begin
                w_dec[B_MEMW]          = 1'b1;
                w_dec[B_OPLO +: 3]     = OP_SW;
                w_reads_ra             = 1'b1;
                w_reads_rb             = 1'b1;
            end
            default: begin
                // BR family; reserved sub-codes stay all-zero and act as NOPs
                case (w_rb)
                    BR_JMP: begin
                        w_dec[B_BRN]       = 1'b1;
                        w_dec[B_OPLO +: 3] = OP_BR;
                        w_reads_ra         = 1'b1;
                    end
                    BR_INCP: begin
                        w_dec[B_INCP]      = 1'b1;
                        w_dec[B_OPLO +: 3] = OP_BR;
                    end
                    BR_DECP: begin
                        w_dec[B_DECP]      = 1'b1;
                        w_dec[B_OPLO +: 3] = OP_BR;
                    end
                    BR_INCB: begin
                        w_dec[B_INCB]      = 1'b1;
                        w_dec[B_OPLO +: 3] = OP_BR;
                    end
                    BR_DECB: begin
                        w_dec[B_DECB]      = 1'b1;
                        w_dec[B_OPLO +: 3] = OP_BR;
                    end
                    default: w_dec = '0;
                endcase
            end
        endcase
    end

    // Only the older instruction in ID/EX is compared, so LW never hazards on itself.
    assign w_match = (w_reads_ra && (r_rd == w_ra)) || (w_reads_rb && (r_rd == w_rb));
    assign hazard_stall = instr_valid && r_valid && r_ctrl[B_MEMR] && w_match && !flush;
    assign instr_ready  = !hazard_stall;
    assign w_bubble_inc = flush || hazard_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
        end else if (flush || hazard_stall || !instr_valid) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
        end else begin
            r_ctrl  <= w_dec;
            r_valid <= 1'b1;
            r_rd    <= w_ra;
            r_ra    <= w_ra;
            r_rb    <= w_rb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_bubble_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ctrl_out     = r_ctrl;
    assign out_valid    = r_valid;
    assign out_rd       = r_rd;
    assign out_ra       = r_ra;
    assign out_rb       = r_rb;
    assign bubble_count = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: vector table plus reset and saturation sequences.
module tb_decode_ctrl_stage;

    logic        clk;
    logic        rst_n;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        flush;

    logic        instr_ready, out_valid, hazard_stall;
    logic [11:0] ctrl_out;
    logic [2:0]  out_rd, out_ra, out_rb;
    logic [15:0] bubble_count;

    logic        s_ready, s_valid, s_stall;
    logic [11:0] s_ctrl;
    logic [2:0]  s_rd, s_ra, s_rb;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    decode_ctrl_stage #(.INSTR_W(9), .REG_AW(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .ctrl_out(ctrl_out),
        .out_valid(out_valid), .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    decode_ctrl_stage #(.INSTR_W(9), .REG_AW(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(s_ready), .flush(flush), .ctrl_out(s_ctrl),
        .out_valid(s_valid), .out_rd(s_rd), .out_ra(s_ra), .out_rb(s_rb),
        .hazard_stall(s_stall), .bubble_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  instr;
        logic        vld;
        logic        fl;
        logic        stall;
        logic [11:0] ctrl;
        logic        ov;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vt[NV];

    function automatic vec_t mk(input logic [8:0] i, input logic v, input logic f,
                                input logic st, input logic [11:0] c, input logic ov,
                                input logic [2:0] rd, input logic [2:0] ra,
                                input logic [2:0] rb, input logic [15:0] cnt);
        vec_t t;
        t.instr = i; t.vld = v; t.fl = f; t.stall = st; t.ctrl = c;
        t.ov = ov; t.rd = rd; t.ra = ra; t.rb = rb; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " ctrl"}, 32'(ctrl_out), 32'h0);
        chk({tag, " valid"}, 32'(out_valid), 32'h0);
        chk({tag, " regs"}, 32'({out_rd, out_ra, out_rb}), 32'h0);
        chk({tag, " count"}, 32'(bubble_count), 32'h0);
    endtask

    initial begin
        // Control encodings: {regW,memR,memW,br,m2r,OP[2:0],incP,decP,incB,decB}
        vt[0]  = mk(9'b100_001_010, 1, 0, 0, 12'h840, 1, 1, 1, 2, 0); // ADD r1,r2
        vt[1]  = mk(9'b000_011_100, 1, 0, 0, 12'h800, 1, 3, 3, 4, 0); // SUB
        vt[2]  = mk(9'b001_101_110, 1, 0, 0, 12'h810, 1, 5, 5, 6, 0); // XOR
        vt[3]  = mk(9'b010_111_000, 1, 0, 0, 12'h820, 1, 7, 7, 0, 0); // SHL
        vt[4]  = mk(9'b011_010_011, 1, 0, 0, 12'h830, 1, 2, 2, 3, 0); // SHR
        vt[5]  = mk(9'b110_001_010, 1, 0, 0, 12'h260, 1, 1, 1, 2, 0); // SW
        vt[6]  = mk(9'b111_100_000, 1, 0, 0, 12'h170, 1, 4, 4, 0, 0); // BR
        vt[7]  = mk(9'b111_000_100, 1, 0, 0, 12'h078, 1, 0, 0, 4, 0); // incPage
        vt[8]  = mk(9'b111_000_101, 1, 0, 0, 12'h074, 1, 0, 0, 5, 0); // decPage
        vt[9]  = mk(9'b111_000_110, 1, 0, 0, 12'h072, 1, 0, 0, 6, 0); // incBranch
        vt[10] = mk(9'b111_000_111, 1, 0, 0, 12'h071, 1, 0, 0, 7, 0); // decBranch
        vt[11] = mk(9'b111_000_001, 1, 0, 0, 12'h000, 1, 0, 0, 1, 0); // reserved NOP
        vt[12] = mk(9'b101_011_001, 1, 0, 0, 12'hCD0, 1, 3, 3, 1, 0); // LW r3,[r1]
        vt[13] = mk(9'b000_011_010, 1, 0, 1, 12'h000, 0, 0, 0, 0, 1); // SUB r3,r2 stalls
        vt[14] = mk(9'b000_011_010, 1, 0, 0, 12'h800, 1, 3, 3, 2, 1); // SUB retried
        vt[15] = mk(9'b101_011_001, 1, 0, 0, 12'hCD0, 1, 3, 3, 1, 1); // LW r3
        vt[16] = mk(9'b100_100_101, 1, 0, 0, 12'h840, 1, 4, 4, 5, 1); // ADD r4,r5 no hazard
        vt[17] = mk(9'b101_011_001, 1, 0, 0, 12'hCD0, 1, 3, 3, 1, 1); // LW r3
        vt[18] = mk(9'b111_011_100, 1, 0, 0, 12'h078, 1, 3, 3, 4, 1); // modifier reads nothing
        vt[19] = mk(9'b101_011_011, 1, 0, 0, 12'hCD0, 1, 3, 3, 3, 1); // LW r3,[r3] no self hazard
        vt[20] = mk(9'b101_010_011, 1, 0, 1, 12'h000, 0, 0, 0, 0, 2); // LW r2,[r3] stalls on rb
        vt[21] = mk(9'b101_010_011, 1, 0, 0, 12'hCD0, 1, 2, 2, 3, 2);
        vt[22] = mk(9'b110_010_000, 1, 0, 1, 12'h000, 0, 0, 0, 0, 3); // SW r2 stalls on ra
        vt[23] = mk(9'b110_010_000, 1, 0, 0, 12'h260, 1, 2, 2, 0, 3);
        vt[24] = mk(9'b101_011_001, 1, 0, 0, 12'hCD0, 1, 3, 3, 1, 3); // LW r3
        vt[25] = mk(9'b000_011_010, 1, 1, 0, 12'h000, 0, 0, 0, 0, 4); // flush beats hazard
        vt[26] = mk(9'b000_011_010, 0, 0, 0, 12'h000, 0, 0, 0, 0, 4); // idle, SUB gone
        vt[27] = mk(9'b101_001_000, 1, 0, 0, 12'hCD0, 1, 1, 1, 0, 4); // LW r1
        vt[28] = mk(9'b000_000_001, 0, 0, 0, 12'h000, 0, 0, 0, 0, 4); // invalid instr: no stall

        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0;
        #12;
        chk_zero_outputs("reset");
        chk("reset ready", 32'(instr_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            instr = vt[i].instr; instr_valid = vt[i].vld; flush = vt[i].fl;
            #1;
            chk($sformatf("v%0d stall", i), 32'(hazard_stall), 32'(vt[i].stall));
            chk($sformatf("v%0d ready", i), 32'(instr_ready), 32'(!vt[i].stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ctrl", i), 32'(ctrl_out), 32'(vt[i].ctrl));
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d rd/ra/rb", i), 32'({out_rd, out_ra, out_rb}),
                32'({vt[i].rd, vt[i].ra, vt[i].rb}));
            chk($sformatf("v%0d count", i), 32'(bubble_count), 32'(vt[i].cnt));
        end

        // Reset while an ADD sits in ID/EX
        @(negedge clk);
        instr = 9'b100_001_010; instr_valid = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset ctrl", 32'(ctrl_out), 32'h840);
        #2 rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk_zero_outputs("mid-stream reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready after reset", 32'(instr_ready), 32'h1);

        // Reset while a load-use stall is active
        @(negedge clk);
        instr = 9'b101_011_001; instr_valid = 1'b1;
        @(negedge clk);
        instr = 9'b000_011_010;
        #1;
        chk("pre-reset stall", 32'(hazard_stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid-stall reset stall", 32'(hazard_stall), 32'h0);
        chk("mid-stall reset ready", 32'(instr_ready), 32'h1);
        chk_zero_outputs("mid-stall reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Five flush cycles: 2-bit counter stops at 3, 16-bit keeps counting
        instr = 9'b000_011_010; instr_valid = 1'b1; flush = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat cnt %0d", k), 32'(s_cnt), (k < 3) ? 32'(k + 1) : 32'h3);
            chk($sformatf("wide cnt %0d", k), 32'(bubble_count), 32'(k + 1));
            chk($sformatf("flush valid %0d", k), 32'(out_valid), 32'h0);
        end
        @(negedge clk);
        flush = 1'b0; instr_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
